acc_cpu_core: RTL and testbench

Parametrised accumulator CPU core, the successor to the fixed 4-bit FSM CPU. It executes one instruction per valid/ready handshake through a three-state FSM against a configurable-width accumulator and a 2^ADDR_W-word internal data memory. It adds carry and zero flags, a carry-chained add, compare and immediate load. It sits under a Tiny Tapeout `tt_um_*` wrapper, which maps `ui_in` and `uio_in` onto the instruction fields and drives `acc` onto `uo_out`.

---
 rtl/acc_cpu_pkg.sv | 29 ++
 rtl/acc_cpu_if.sv | 26 ++
 rtl/acc_cpu_alu.sv | 98 +++++++++
 rtl/acc_cpu_core.sv | 113 +++++++++++
 tb/tb_acc_cpu_core.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/acc_cpu_pkg.sv
// Shared definitions for the accumulator CPU core: opcode encodings and FSM states.
package acc_cpu_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADD   = 4'h0;
  localparam logic [OP_W-1:0] OP_SUB   = 4'h1;
  localparam logic [OP_W-1:0] OP_STORE = 4'h2;
  localparam logic [OP_W-1:0] OP_LOAD  = 4'h3;
  localparam logic [OP_W-1:0] OP_LDI   = 4'h4;
  localparam logic [OP_W-1:0] OP_AND   = 4'h5;
  localparam logic [OP_W-1:0] OP_OR    = 4'h6;
  localparam logic [OP_W-1:0] OP_XOR   = 4'h7;
  localparam logic [OP_W-1:0] OP_NOT   = 4'h8;
  localparam logic [OP_W-1:0] OP_SHL   = 4'h9;
  localparam logic [OP_W-1:0] OP_SHR   = 4'hA;
  localparam logic [OP_W-1:0] OP_ADDM  = 4'hB;
  localparam logic [OP_W-1:0] OP_CMP   = 4'hC;
  localparam logic [OP_W-1:0] OP_ADC   = 4'hD;
  localparam logic [OP_W-1:0] OP_NOP   = 4'hE;
  localparam logic [OP_W-1:0] OP_CLR   = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/acc_cpu_if.sv
// Instruction handshake and architectural-state bus between a source and the core.
interface acc_cpu_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
);
  logic              ena;
  logic              instr_valid;
  logic              instr_ready;
  logic [3:0]        opcode;
  logic [DATA_W-1:0] operand;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] acc;
  logic              flag_c;
  logic              flag_z;
  logic              done;

  modport master (
    output ena, instr_valid, opcode, operand, addr,
    input  instr_ready, acc, flag_c, flag_z, done
  );

  modport slave (
    input  ena, instr_valid, opcode, operand, addr,
    output instr_ready, acc, flag_c, flag_z, done
  );
endinterface

// File: rtl/acc_cpu_alu.sv
// Combinational datapath: computes the result, flags and write strobes for one opcode.
module acc_cpu_alu
  import acc_cpu_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic [3:0]        opcode_i,
  input  logic [DATA_W-1:0] acc_i,
  input  logic [DATA_W-1:0] operand_i,
  input  logic [DATA_W-1:0] mem_i,
  input  logic              carry_i,
  output logic [DATA_W-1:0] result_o,
  output logic              carry_o,
  output logic              zero_o,
  output logic              wr_acc_o,
  output logic              wr_flags_o
);

  logic [DATA_W-1:0] add_b;
  logic              add_cin;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;

  // One shared adder serves ADD, ADDM and ADC; bit DATA_W is the carry out.
  assign add_b   = (opcode_i == OP_ADDM) ? mem_i : operand_i;
  assign add_cin = (opcode_i == OP_ADC) ? carry_i : 1'b0;
  assign sum     = {1'b0, acc_i} + {1'b0, add_b} + {{DATA_W{1'b0}}, add_cin};
  assign diff    = {1'b0, acc_i} - {1'b0, operand_i};

  // NOTE: every output gets a default before the case, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    result_o   = acc_i;
    carry_o    = carry_i;
    wr_acc_o   = 1'b0;
    wr_flags_o = 1'b0;
    case (opcode_i)
      OP_ADD, OP_ADDM, OP_ADC: begin
        {carry_o, result_o} = sum;
        wr_acc_o   = 1'b1;
        wr_flags_o = 1'b1;
      end
      OP_SUB: begin
        {carry_o, result_o} = diff;
        wr_acc_o   = 1'b1;
        wr_flags_o = 1'b1;
      end
      OP_CMP: begin
        {carry_o, result_o} = diff;
        wr_flags_o = 1'b1;
      end
      OP_LOAD: begin
        result_o   = mem_i;
        wr_acc_o   = 1'b1;
        wr_flags_o = 1'b1;
      end
      OP_LDI: begin
        result_o   = operand_i;
        wr_acc_o   = 1'b1;
        wr_flags_o = 1'b1;
      end
      OP_AND, OP_OR, OP_XOR, OP_NOT: begin
        case (opcode_i)
          OP_AND:  result_o = acc_i & operand_i;
          OP_OR:   result_o = acc_i | operand_i;
          OP_XOR:  result_o = acc_i ^ operand_i;
          default: result_o = ~acc_i;
        endcase
        carry_o    = 1'b0;
        wr_acc_o   = 1'b1;
        wr_flags_o = 1'b1;
      end
      OP_SHL: begin
        result_o   = {acc_i[DATA_W-2:0], 1'b0};
        carry_o    = acc_i[DATA_W-1];
        wr_acc_o   = 1'b1;
        wr_flags_o = 1'b1;
      end
      OP_SHR: begin
        result_o   = {1'b0, acc_i[DATA_W-1:1]};
        carry_o    = acc_i[0];
        wr_acc_o   = 1'b1;
        wr_flags_o = 1'b1;
      end
      OP_CLR: begin
        result_o   = '0;
        carry_o    = 1'b0;
        wr_acc_o   = 1'b1;
        wr_flags_o = 1'b1;
      end
      default: ;
    endcase
  end

  // CMP leaves acc alone but still reports zero of the difference.
  assign zero_o = (result_o == '0);

endmodule

// File: rtl/acc_cpu_core.sv
// Accumulator CPU core: IDLE/EXEC/DONE handshake FSM, instruction latch,
// acc/flag registers and a flop-based data memory.
module acc_cpu_core
  import acc_cpu_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  acc_cpu_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;

  state_e            state_q, state_d;
  logic [3:0]        op_q;
  logic [DATA_W-1:0] operand_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] acc_q;
  logic              flag_c_q, flag_z_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              ready, done, accept, exec;
  logic [DATA_W-1:0] alu_result, mem_rd;
  logic              alu_carry, alu_zero, alu_wr_acc, alu_wr_flags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready = bus.ena;
        if (bus.instr_valid && bus.ena) state_d = S_EXEC;
      end
      S_EXEC:  state_d = S_DONE;
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign accept = bus.instr_valid & ready;
  assign exec   = (state_q == S_EXEC);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= OP_NOP;
      operand_q <= '0;
      addr_q    <= '0;
    end else if (accept) begin
      op_q      <= bus.opcode;
      operand_q <= bus.operand;
      addr_q    <= bus.addr;
    end
  end

  assign mem_rd = mem_q[addr_q];

  acc_cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .opcode_i   (op_q),
    .acc_i      (acc_q),
    .operand_i  (operand_q),
    .mem_i      (mem_rd),
    .carry_i    (flag_c_q),
    .result_o   (alu_result),
    .carry_o    (alu_carry),
    .zero_o     (alu_zero),
    .wr_acc_o   (alu_wr_acc),
    .wr_flags_o (alu_wr_flags)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else if (exec) begin
      if (alu_wr_acc) acc_q <= alu_result;
      if (alu_wr_flags) begin
        flag_c_q <= alu_carry;
        flag_z_q <= alu_zero;
      end
    end
  end

  // NOTE: the memory is cleared by reset on purpose: software may LOAD any
  // word straight out of reset and must read zero, so it cannot map to a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (exec && op_q == OP_STORE) begin
      mem_q[addr_q] <= acc_q;
    end
  end

  assign bus.instr_ready = ready;
  assign bus.done        = done;
  assign bus.acc         = acc_q;
  assign bus.flag_c      = flag_c_q;
  assign bus.flag_z      = flag_z_q;

endmodule

// File: tb/tb_acc_cpu_core.sv
// Directed scoreboard bench for acc_cpu_core at DATA_W=4 and DATA_W=8.
module tb_acc_cpu_core;
  import acc_cpu_pkg::*;

  typedef struct {
    logic [7:0] acc;
    logic       c;
    logic       z;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t sb_q[$];

  acc_cpu_if #(.DATA_W(4), .ADDR_W(4)) a_if ();
  acc_cpu_if #(.DATA_W(8), .ADDR_W(4)) b_if ();

  acc_cpu_core #(.DATA_W(4), .ADDR_W(4)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
  acc_cpu_core #(.DATA_W(8), .ADDR_W(4)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_pop(input string tag, input logic [7:0] acc, input logic c, input logic z);
    exp_t e;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd1);
      return;
    end
    e = sb_q.pop_front();
    check({tag, "_acc"}, 32'(acc), 32'(e.acc));
    check({tag, "_c"},   32'(c),   32'(e.c));
    check({tag, "_z"},   32'(z),   32'(e.z));
  endtask

  task automatic issue_a(input logic [3:0] op, input logic [3:0] opnd, input logic [3:0] ad,
                         input logic [3:0] e_acc, input logic e_c, input logic e_z,
                         input bit drop_ena = 1'b0);
    int    cyc;
    string tag;
    tag = $sformatf("a_op%0h_%0h", op, opnd);
    sb_q.push_back('{acc: {4'h0, e_acc}, c: e_c, z: e_z});
    @(negedge clk);
    a_if.opcode      = op;
    a_if.operand     = opnd;
    a_if.addr        = ad;
    a_if.instr_valid = 1'b1;
    cyc = 0;
    while (!a_if.instr_ready && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_ready_idle"}, 32'(a_if.instr_ready), 32'd1);
    @(posedge clk);
    #1;
    a_if.instr_valid = 1'b0;
    if (drop_ena) a_if.ena = 1'b0;
    check({tag, "_ready_exec"}, 32'(a_if.instr_ready), 32'd0);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!a_if.done && cyc < 6);
    check({tag, "_done_lat"}, 32'(cyc), 32'd1);
    check({tag, "_ready_done"}, 32'(a_if.instr_ready), 32'd0);
    compare_pop(tag, {4'h0, a_if.acc}, a_if.flag_c, a_if.flag_z);
    @(posedge clk);
    #1;
    check({tag, "_done_clr"}, 32'(a_if.done), 32'd0);
    check({tag, "_ready_back"}, 32'(a_if.instr_ready), 32'(!drop_ena));
    a_if.ena = 1'b1;
  endtask

  task automatic issue_b(input logic [3:0] op, input logic [7:0] opnd,
                         input logic [7:0] e_acc, input logic e_c, input logic e_z);
    int    cyc;
    string tag;
    tag = $sformatf("b_op%0h_%0h", op, opnd);
    sb_q.push_back('{acc: e_acc, c: e_c, z: e_z});
    @(negedge clk);
    b_if.opcode      = op;
    b_if.operand     = opnd;
    b_if.addr        = 4'h0;
    b_if.instr_valid = 1'b1;
    cyc = 0;
    while (!b_if.instr_ready && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    @(posedge clk);
    #1;
    b_if.instr_valid = 1'b0;
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!b_if.done && cyc < 6);
    check({tag, "_done_lat"}, 32'(cyc), 32'd1);
    compare_pop(tag, b_if.acc, b_if.flag_c, b_if.flag_z);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    a_if.ena = 1'b1; a_if.instr_valid = 1'b0; a_if.opcode = 4'h0; a_if.operand = '0; a_if.addr = '0;
    b_if.ena = 1'b1; b_if.instr_valid = 1'b0; b_if.opcode = 4'h0; b_if.operand = '0; b_if.addr = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_acc",   32'(a_if.acc),         32'd0);
    check("rst_c",     32'(a_if.flag_c),      32'd0);
    check("rst_z",     32'(a_if.flag_z),      32'd0);
    check("rst_ready", 32'(a_if.instr_ready), 32'd1);
    check("rst_done",  32'(a_if.done),        32'd0);

    for (int i = 0; i < 16; i++) issue_a(OP_LOAD, 4'h0, i[3:0], 4'h0, 1'b0, 1'b1);

    issue_a(OP_LDI,   4'h7, 4'h0, 4'h7, 1'b0, 1'b0);
    issue_a(OP_ADD,   4'h9, 4'h0, 4'h0, 1'b1, 1'b1);
    issue_a(OP_LDI,   4'hA, 4'h0, 4'hA, 1'b1, 1'b0);
    issue_a(OP_STORE, 4'h0, 4'h5, 4'hA, 1'b1, 1'b0);
    issue_a(OP_LDI,   4'h0, 4'h0, 4'h0, 1'b1, 1'b1);
    issue_a(OP_LOAD,  4'h0, 4'h5, 4'hA, 1'b1, 1'b0);
    issue_a(OP_LOAD,  4'h0, 4'h6, 4'h0, 1'b1, 1'b1);

    issue_a(OP_LDI,   4'h1, 4'h0, 4'h1, 1'b1, 1'b0);
    issue_a(OP_SUB,   4'h3, 4'h0, 4'hE, 1'b1, 1'b0);
    issue_a(OP_CMP,   4'hE, 4'h0, 4'hE, 1'b0, 1'b1);
    issue_a(OP_ADC,   4'h1, 4'h0, 4'hF, 1'b0, 1'b0);

    issue_a(OP_LDI,   4'h9, 4'h0, 4'h9, 1'b0, 1'b0);
    issue_a(OP_SHL,   4'h0, 4'h0, 4'h2, 1'b1, 1'b0);
    issue_a(OP_ADC,   4'h0, 4'h0, 4'h3, 1'b0, 1'b0);

    issue_a(OP_AND,   4'h6, 4'h0, 4'h2, 1'b0, 1'b0);
    issue_a(OP_OR,    4'h8, 4'h0, 4'hA, 1'b0, 1'b0);
    issue_a(OP_XOR,   4'hA, 4'h0, 4'h0, 1'b0, 1'b1);
    issue_a(OP_NOT,   4'h0, 4'h0, 4'hF, 1'b0, 1'b0);
    issue_a(OP_SHR,   4'h0, 4'h0, 4'h7, 1'b1, 1'b0);
    issue_a(OP_ADDM,  4'h0, 4'h5, 4'h1, 1'b1, 1'b0);
    issue_a(OP_NOP,   4'h3, 4'h0, 4'h1, 1'b1, 1'b0);
    issue_a(OP_CLR,   4'h0, 4'h0, 4'h0, 1'b0, 1'b1);

    // Valid held while disabled must not be taken.
    @(negedge clk);
    a_if.ena = 1'b0; a_if.opcode = OP_LDI; a_if.operand = 4'h5; a_if.instr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("dis_ready_%0d", i), 32'(a_if.instr_ready), 32'd0);
      check($sformatf("dis_done_%0d", i),  32'(a_if.done),        32'd0);
    end
    a_if.instr_valid = 1'b0;
    a_if.ena = 1'b1;
    issue_a(OP_NOP, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);

    issue_a(OP_LDI, 4'h5, 4'h0, 4'h5, 1'b0, 1'b0, 1'b1);

    // Reset lands while a STORE is in EXEC.
    @(negedge clk);
    a_if.opcode = OP_STORE; a_if.operand = 4'h0; a_if.addr = 4'h3; a_if.instr_valid = 1'b1;
    @(posedge clk);
    #1;
    a_if.instr_valid = 1'b0;
    check("abort_in_exec", 32'(a_if.instr_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_acc",   32'(a_if.acc),         32'd0);
    check("abort_ready", 32'(a_if.instr_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("abort_done_%0d", i), 32'(a_if.done), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    issue_a(OP_LOAD, 4'h0, 4'h3, 4'h0, 1'b0, 1'b1);

    issue_b(OP_LDI, 8'hFF, 8'hFF, 1'b0, 1'b0);
    issue_b(OP_ADD, 8'h01, 8'h00, 1'b1, 1'b1);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
